huff_table_builder: RTL and testbench
=====================================

Name: huff_table_builder

Overview:
- Parametrised canonical-Huffman table builder: next generation of the tree generator in the inflate core.
- Reads per-symbol code lengths from an external length buffer and computes DEFLATE canonical codes (RFC 1951 §3.2.2).
- Writes a {code, len} entry per symbol into the decode table consumed by the Huffman decoder.
- Generalised over symbol count, maximum code length, buffer/table base offsets and output bit order; adds oversubscribed/incomplete code-set detection.

Parameters:
- MAX_SYMS, 288, largest symbol count per build.
- MAX_LEN, 15, maximum code length; also the code width.
- LEN_W, 4, width of a length entry.
- BUF_AW, 9, length-buffer address width.
- TBL_AW, 9, decode-table address width.
- BIT_REVERSE, 0, 1 = write codes bit-reversed within len (LSB-first stream order).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  build request pulse.
- sym_num  in  $clog2(MAX_SYMS+1)  symbols in this build, 1..MAX_SYMS; sampled with start.
- buf_base  in  BUF_AW  length-buffer offset; sampled with start.
- tbl_base  in  TBL_AW  table offset; sampled with start.
- len_rd_addr  out  BUF_AW  length-buffer read address.
- len_rd_data  in  LEN_W  length; valid one cycle after the address (registered RAM).
- tbl_wr_en  out  1  table write strobe.
- tbl_wr_addr  out  TBL_AW  table address.
- tbl_wr_code  out  MAX_LEN  code, right-aligned.
- tbl_wr_len  out  LEN_W  code length (0 = unused symbol).
- busy  out  1  build in progress.
- done  out  1  one-cycle completion pulse.
- err_over  out  1  oversubscribed code set; sticky until next accepted start.
- err_incomplete  out  1  incomplete code set (non-fatal); sticky until next accepted start.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; bl_count and next_code cleared.
- Start acceptance: start is accepted only when busy=0 and is ignored while busy.
- On an accepted start:
  - Latch sym_num, buf_base and tbl_base.
  - Clear bl_count[0..MAX_LEN] and both error flags.
  - busy=1 from the next cycle.
- FSM: IDLE -> CNT -> NEXT -> ASSIGN -> FIN -> IDLE.
- CNT (sym_num+1 cycles):
  - Issues len_rd_addr = buf_base+i for i = 0..sym_num-1, one address per cycle.
  - Returned data increments bl_count[len] one cycle later; len 0 is not counted.
  - Any len > MAX_LEN sets err_over.
- NEXT (MAX_LEN cycles, one length per cycle, L = 1..MAX_LEN):
  - code = (code + bl_count[L-1]) << 1, with bl_count[0] treated as 0.
  - next_code[L] = code.
  - If code + bl_count[L] > 2^L, set err_over. Arithmetic is MAX_LEN+2 bits; no wrap.
  - After L = MAX_LEN: if no overflow and the Kraft sum < 1 (code + bl_count[MAX_LEN] < 2^MAX_LEN) with at least one nonzero length, set err_incomplete.
  - If err_over is set, skip ASSIGN and go directly to FIN: no table writes occur.
- ASSIGN (sym_num+1 cycles):
  - Re-reads the lengths in order i = 0..sym_num-1.
  - One cycle after each read: tbl_wr_en=1, tbl_wr_addr = tbl_base+i, tbl_wr_len = len.
  - If len != 0: tbl_wr_code = next_code[len], then next_code[len]++.
  - If len == 0: tbl_wr_code = 0. The entry is still written so stale entries are cleared.
  - With BIT_REVERSE=1, the low len bits of the code are reversed and the upper bits are 0.
  - Exactly sym_num writes occur, in ascending address order, with no gaps.
- FIN (1 cycle): done=1, busy=0 on the following cycle; returns to IDLE.
- Latency (start-sample edge to done high):
  - Normal build: 2*sym_num + MAX_LEN + 3 cycles.
  - Oversubscribed build: sym_num + MAX_LEN + 2 cycles.
- Outside ASSIGN, tbl_wr_en=0. len_rd_addr holds its last value when no read is issued.
- Reset mid-build: immediate return to IDLE with all outputs 0. A partially written table is not restored.
- All-zero lengths: complete build, sym_num writes of len 0, no error flags.
- Single nonzero length of 1: valid DEFLATE distance case; code 0 is written and err_incomplete=1.

Test Plan:
- Lengths {3,3,3,4,3,2,0,4,0,3}, sym_num=10, BIT_REVERSE=0 -> codes 010,011,100,1110,101,00,-,1111,-,110; no error flags; done at cycle 2*10+15+3 = 38.
- RFC example lengths {3,3,3,3,3,2,4,4}, tbl_base=32 -> writes to addresses 32..39 with codes 010,011,100,101,110,00,1110,1111.
- Same lengths with BIT_REVERSE=1 -> sym4 (len 3, code 110) writes 011; sym6 (len 4, code 1110) writes 0111.
- Lengths {1,1,1} -> err_over=1, zero table writes, done at cycle 3+15+2 = 20.
- Lengths {0,1,0} -> sym1 gets code 0 len 1; err_incomplete=1; err_over=0.
- Start pulsed during CNT is ignored. Reset asserted during ASSIGN: busy/done/tbl_wr_en drop to 0 immediately; a subsequent start performs a clean full rebuild.

Source files
------------

// File: rtl/huff_table_builder.sv
// Canonical-Huffman decode table builder.
// The builder reads per-symbol code lengths, histograms them, derives the
// first code of each length and then writes one {code, len} entry per symbol.
// It also flags oversubscribed code sets (fatal, no table written) and
// incomplete code sets (non-fatal).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start, busy=0
// S_CNT    | stream lengths in, build bl_count[]
// S_NEXT   | one code length per cycle: next_code[], Kraft check
// S_ASSIGN | stream lengths again, write one table entry per symbol
// S_FIN    | single cycle; done pulses on the following cycle
module huff_table_builder #(
  parameter int MAX_SYMS    = 288,
  parameter int MAX_LEN     = 15,
  parameter int LEN_W       = 4,
  parameter int BUF_AW      = 9,
  parameter int TBL_AW      = 9,
  parameter int BIT_REVERSE = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [$clog2(MAX_SYMS+1)-1:0]     sym_num,
  input  logic [BUF_AW-1:0]                 buf_base,
  input  logic [TBL_AW-1:0]                 tbl_base,
  output logic [BUF_AW-1:0]                 len_rd_addr,
  input  logic [LEN_W-1:0]                  len_rd_data,
  output logic                              tbl_wr_en,
  output logic [TBL_AW-1:0]                 tbl_wr_addr,
  output logic [MAX_LEN-1:0]                tbl_wr_code,
  output logic [LEN_W-1:0]                  tbl_wr_len,
  output logic                              busy,
  output logic                              done,
  output logic                              err_over,
  output logic                              err_incomplete
);

  localparam int SYM_W = $clog2(MAX_SYMS + 1);
  localparam int LC_W  = $clog2(MAX_LEN + 1);
  // Kraft arithmetic width: code <= 2^L plus a full symbol count never wraps.
  localparam int CW    = MAX_LEN + 2;
  localparam logic [LEN_W:0] MAX_LEN_X = (LEN_W + 1)'(MAX_LEN);

  typedef enum logic [2:0] {S_IDLE, S_CNT, S_NEXT, S_ASSIGN, S_FIN} state_t;
  state_t state_q, state_d;

  logic [SYM_W-1:0]   num_q;
  logic [SYM_W-1:0]   idx_q;
  logic [SYM_W-1:0]   wr_idx_q;
  logic [BUF_AW-1:0]  buf_base_q;
  logic [TBL_AW-1:0]  tbl_base_q;
  logic               vld_q;
  logic               any_len_q;
  logic [LC_W-1:0]    l_q;
  logic [CW-1:0]      code_q;
  logic [SYM_W-1:0]   bl_count [0:MAX_LEN];
  logic [MAX_LEN-1:0] next_code [0:MAX_LEN];

  logic               issue;
  logic               len_ok;
  logic               wr_fire;
  logic [CW-1:0]      prev_cnt;
  logic [CW-1:0]      code_new;
  logic [CW-1:0]      kraft_sum;
  logic [CW-1:0]      pow_l;
  logic               over_now;
  logic               last_len;
  logic [MAX_LEN-1:0] raw_code;
  logic [MAX_LEN-1:0] rev_full;
  logic [MAX_LEN-1:0] out_code;
  logic [LEN_W:0]     rev_sh;

  assign issue   = (idx_q < num_q);
  assign len_ok  = ({1'b0, len_rd_data} <= MAX_LEN_X);
  assign wr_fire = (state_q == S_ASSIGN) && vld_q;

  // First-code recurrence for the length currently addressed by l_q.
  always_comb begin
    prev_cnt = '0;
    if (l_q > LC_W'(1)) prev_cnt = CW'(bl_count[l_q - LC_W'(1)]);
    code_new  = (code_q + prev_cnt) << 1;
    kraft_sum = code_new + CW'(bl_count[l_q]);
    pow_l     = CW'(1) << l_q;
    over_now  = (kraft_sum > pow_l);
    last_len  = (l_q == LC_W'(MAX_LEN));
  end

  // Code lookup and optional LSB-first reversal within the code length:
  // reverse all MAX_LEN bits, then shift the unused upper positions out.
  always_comb begin
    raw_code = next_code[len_rd_data];
    rev_full = '0;
    for (int j = 0; j < MAX_LEN; j++) rev_full[MAX_LEN-1-j] = raw_code[j];
    rev_sh   = MAX_LEN_X - {1'b0, len_rd_data};
    out_code = (BIT_REVERSE != 0) ? (rev_full >> rev_sh) : raw_code;
  end

  // Table write port is driven straight from the returning length data.
  always_comb begin
    tbl_wr_en   = wr_fire;
    tbl_wr_addr = '0;
    tbl_wr_len  = '0;
    tbl_wr_code = '0;
    if (wr_fire) begin
      tbl_wr_addr = tbl_base_q + TBL_AW'(wr_idx_q);
      tbl_wr_len  = len_rd_data;
      if (len_rd_data != '0) tbl_wr_code = out_code;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; an oversubscribed set bypasses table assignment.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_CNT;
      S_CNT:    if (!issue) state_d = S_NEXT;
      S_NEXT:   if (last_len) state_d = (err_over || over_now) ? S_FIN : S_ASSIGN;
      S_ASSIGN: if (!issue) state_d = S_FIN;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: read sequencing, histogram, next_code table, flags, handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q          <= '0;
      idx_q          <= '0;
      wr_idx_q       <= '0;
      buf_base_q     <= '0;
      tbl_base_q     <= '0;
      vld_q          <= 1'b0;
      any_len_q      <= 1'b0;
      l_q            <= '0;
      code_q         <= '0;
      len_rd_addr    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_over       <= 1'b0;
      err_incomplete <= 1'b0;
      for (int k = 0; k <= MAX_LEN; k++) begin
        bl_count[k]  <= '0;
        next_code[k] <= '0;
      end
    end else begin
      done  <= 1'b0;
      vld_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            num_q          <= sym_num;
            buf_base_q     <= buf_base;
            tbl_base_q     <= tbl_base;
            len_rd_addr    <= buf_base;
            idx_q          <= '0;
            any_len_q      <= 1'b0;
            err_over       <= 1'b0;
            err_incomplete <= 1'b0;
            busy           <= 1'b1;
            for (int k = 0; k <= MAX_LEN; k++) bl_count[k] <= '0;
          end
        end
        S_CNT, S_ASSIGN: begin
          if (issue) begin
            vld_q    <= 1'b1;
            wr_idx_q <= idx_q;
            idx_q    <= idx_q + SYM_W'(1);
            if (idx_q + SYM_W'(1) < num_q) len_rd_addr <= len_rd_addr + BUF_AW'(1);
          end
          if (state_q == S_CNT) begin
            l_q    <= LC_W'(1);
            code_q <= '0;
            if (vld_q && len_rd_data != '0) begin
              if (len_ok) begin
                bl_count[len_rd_data] <= bl_count[len_rd_data] + SYM_W'(1);
                any_len_q <= 1'b1;
              end else begin
                err_over <= 1'b1;
              end
            end
          end else if (vld_q && len_rd_data != '0 && len_ok) begin
            next_code[len_rd_data] <= next_code[len_rd_data] + MAX_LEN'(1);
          end
        end
        S_NEXT: begin
          code_q         <= code_new;
          next_code[l_q] <= code_new[MAX_LEN-1:0];
          l_q            <= l_q + LC_W'(1);
          if (over_now) err_over <= 1'b1;
          if (last_len) begin
            if (!err_over && !over_now && kraft_sum < pow_l && any_len_q)
              err_incomplete <= 1'b1;
            idx_q       <= '0;
            len_rd_addr <= buf_base_q;
          end
        end
        S_FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_huff_table_builder.sv
// Directed bench for huff_table_builder: one instance in MSB-first order and
// one in bit-reversed order, sharing a registered length-buffer model.
module tb_huff_table_builder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, start_b;
  logic [8:0]  sym_num, buf_base, tbl_base;

  logic [8:0]  rd_addr_a, rd_addr_b;
  logic [3:0]  rd_data_a, rd_data_b;
  logic        wr_en_a, wr_en_b;
  logic [8:0]  wr_addr_a, wr_addr_b;
  logic [14:0] wr_code_a, wr_code_b;
  logic [3:0]  wr_len_a, wr_len_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic        eo_a, eo_b, ei_a, ei_b;

  logic [3:0]  len_mem [0:511];

  int checks   = 0;
  int failures = 0;

  logic [8:0]  la_addr [0:511];
  logic [14:0] la_code [0:511];
  logic [3:0]  la_len  [0:511];
  int          la_n = 0;
  logic [8:0]  lb_addr [0:511];
  logic [14:0] lb_code [0:511];
  logic [3:0]  lb_len  [0:511];
  int          lb_n = 0;

  huff_table_builder #(.BIT_REVERSE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .sym_num(sym_num),
    .buf_base(buf_base), .tbl_base(tbl_base),
    .len_rd_addr(rd_addr_a), .len_rd_data(rd_data_a),
    .tbl_wr_en(wr_en_a), .tbl_wr_addr(wr_addr_a), .tbl_wr_code(wr_code_a),
    .tbl_wr_len(wr_len_a), .busy(busy_a), .done(done_a),
    .err_over(eo_a), .err_incomplete(ei_a)
  );

  huff_table_builder #(.BIT_REVERSE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .sym_num(sym_num),
    .buf_base(buf_base), .tbl_base(tbl_base),
    .len_rd_addr(rd_addr_b), .len_rd_data(rd_data_b),
    .tbl_wr_en(wr_en_b), .tbl_wr_addr(wr_addr_b), .tbl_wr_code(wr_code_b),
    .tbl_wr_len(wr_len_b), .busy(busy_b), .done(done_b),
    .err_over(eo_b), .err_incomplete(ei_b)
  );

  // Registered-read length buffers.
  always @(posedge clk) begin
    rd_data_a <= len_mem[rd_addr_a];
    rd_data_b <= len_mem[rd_addr_b];
  end

  // Table write loggers, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en_a && la_n < 512) begin
      la_addr[la_n] <= wr_addr_a;
      la_code[la_n] <= wr_code_a;
      la_len[la_n]  <= wr_len_a;
      la_n          <= la_n + 1;
    end
    if (wr_en_b && lb_n < 512) begin
      lb_addr[lb_n] <= wr_addr_b;
      lb_code[lb_n] <= wr_code_b;
      lb_len[lb_n]  <= wr_len_b;
      lb_n          <= lb_n + 1;
    end
  end

  // Launch a build and count edges from the start-sample edge until done.
  // glitch: cycle at which a stray start is pulsed; abort: return early.
  // snap holds {busy, err_over, err_incomplete} just after the start edge.
  task automatic run_build(input bit sel, input int n, input int bb, input int tbb,
                           input int glitch, input int abort,
                           output int lat, output logic [2:0] snap);
    @(negedge clk);
    sym_num  = 9'(n);
    buf_base = 9'(bb);
    tbl_base = 9'(tbb);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    snap = sel ? {busy_b, eo_b, ei_b} : {busy_a, eo_a, ei_a};
    lat = 0;
    for (int c = 0; c < 1000; c++) begin
      if (lat == glitch) begin
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        sym_num  = 9'd3;
        buf_base = 9'd300;
        tbl_base = 9'd50;
      end else begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (sel ? done_b : done_a) begin
        start_a = 1'b0;
        start_b = 1'b0;
        return;
      end
      if (lat == abort) return;
    end
    start_a = 1'b0;
    start_b = 1'b0;
    lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy_a, done_a, eo_a, ei_a, wr_en_a} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got %b exp 00000", {busy_a, done_a, eo_a, ei_a, wr_en_a});
    end
    checks++;
    if (rd_addr_a !== 9'd0 || wr_addr_a !== 9'd0 || wr_code_a !== 15'd0) begin
      failures++;
      $display("FAIL reset_buses got rd=%0d wa=%0d wc=%0d exp 0", rd_addr_a, wr_addr_a, wr_code_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int l[10]  = '{3, 3, 3, 4, 3, 2, 0, 4, 0, 3};
    int ec[10] = '{2, 3, 4, 14, 5, 0, 0, 15, 0, 6};
    int lat, wb;
    logic [2:0] snap;
    for (int i = 0; i < 10; i++) len_mem[100 + i] = 4'(l[i]);
    wb = la_n;
    run_build(1'b0, 10, 100, 0, -1, -1, lat, snap);
    checks++;
    if (snap !== 3'b100) begin
      failures++;
      $display("FAIL basic_busy_after_start got %b exp 100", snap);
    end
    checks++;
    if (lat !== 38) begin
      failures++;
      $display("FAIL basic_latency got %0d exp 38", lat);
    end
    checks++;
    if (la_n - wb !== 10) begin
      failures++;
      $display("FAIL basic_write_count got %0d exp 10", la_n - wb);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (la_addr[wb+i] !== 9'(i) || la_code[wb+i] !== 15'(ec[i]) || la_len[wb+i] !== 4'(l[i])) begin
        failures++;
        $display("FAIL basic_entry%0d got a=%0d c=%0d l=%0d exp a=%0d c=%0d l=%0d",
                 i, la_addr[wb+i], la_code[wb+i], la_len[wb+i], i, ec[i], l[i]);
      end
    end
    checks++;
    if ({eo_a, ei_a, busy_a} !== 3'b000 || rd_addr_a !== 9'd109) begin
      failures++;
      $display("FAIL basic_end_state got eo=%b ei=%b busy=%b rd=%0d exp 0 0 0 109",
               eo_a, ei_a, busy_a, rd_addr_a);
    end
    @(posedge clk); #1;
    checks++;
    if (done_a !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse got %b exp 0", done_a);
    end
  endtask

  task automatic test_rfc();
    int l[8]  = '{3, 3, 3, 3, 3, 2, 4, 4};
    int ec[8] = '{2, 3, 4, 5, 6, 0, 14, 15};
    int lat, wb;
    logic [2:0] snap;
    for (int i = 0; i < 8; i++) len_mem[200 + i] = 4'(l[i]);
    wb = la_n;
    run_build(1'b0, 8, 200, 32, -1, -1, lat, snap);
    checks++;
    if (lat !== 34 || la_n - wb !== 8) begin
      failures++;
      $display("FAIL rfc_latency_count got lat=%0d n=%0d exp 34 8", lat, la_n - wb);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (la_addr[wb+i] !== 9'(32 + i) || la_code[wb+i] !== 15'(ec[i]) || la_len[wb+i] !== 4'(l[i])) begin
        failures++;
        $display("FAIL rfc_entry%0d got a=%0d c=%0d l=%0d exp a=%0d c=%0d l=%0d",
                 i, la_addr[wb+i], la_code[wb+i], la_len[wb+i], 32 + i, ec[i], l[i]);
      end
    end
  endtask

  task automatic test_bit_reverse();
    int l[8]  = '{3, 3, 3, 3, 3, 2, 4, 4};
    int ec[8] = '{2, 6, 1, 5, 3, 0, 7, 15};
    int lat, wb;
    logic [2:0] snap;
    for (int i = 0; i < 8; i++) len_mem[200 + i] = 4'(l[i]);
    wb = lb_n;
    run_build(1'b1, 8, 200, 32, -1, -1, lat, snap);
    checks++;
    if (lat !== 34 || lb_n - wb !== 8) begin
      failures++;
      $display("FAIL rev_latency_count got lat=%0d n=%0d exp 34 8", lat, lb_n - wb);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (lb_addr[wb+i] !== 9'(32 + i) || lb_code[wb+i] !== 15'(ec[i]) || lb_len[wb+i] !== 4'(l[i])) begin
        failures++;
        $display("FAIL rev_entry%0d got a=%0d c=%0d l=%0d exp a=%0d c=%0d l=%0d",
                 i, lb_addr[wb+i], lb_code[wb+i], lb_len[wb+i], 32 + i, ec[i], l[i]);
      end
    end
  endtask

  task automatic test_over();
    int lat, wb;
    logic [2:0] snap;
    for (int i = 0; i < 3; i++) len_mem[300 + i] = 4'd1;
    wb = la_n;
    run_build(1'b0, 3, 300, 400, -1, -1, lat, snap);
    checks++;
    if (lat !== 20) begin
      failures++;
      $display("FAIL over_latency got %0d exp 20", lat);
    end
    checks++;
    if (la_n - wb !== 0) begin
      failures++;
      $display("FAIL over_no_writes got %0d exp 0", la_n - wb);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({eo_a, ei_a} !== 2'b10) begin
      failures++;
      $display("FAIL over_flags_sticky got %b exp 10", {eo_a, ei_a});
    end
  endtask

  task automatic test_incomplete();
    int l[3] = '{0, 1, 0};
    int lat, wb;
    logic [2:0] snap;
    for (int i = 0; i < 3; i++) len_mem[310 + i] = 4'(l[i]);
    wb = la_n;
    run_build(1'b0, 3, 310, 7, -1, -1, lat, snap);
    checks++;
    if (snap !== 3'b100) begin
      failures++;
      $display("FAIL incomplete_flags_cleared got %b exp 100", snap);
    end
    checks++;
    if (lat !== 24 || la_n - wb !== 3) begin
      failures++;
      $display("FAIL incomplete_latency_count got lat=%0d n=%0d exp 24 3", lat, la_n - wb);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (la_addr[wb+i] !== 9'(7 + i) || la_code[wb+i] !== 15'd0 || la_len[wb+i] !== 4'(l[i])) begin
        failures++;
        $display("FAIL incomplete_entry%0d got a=%0d c=%0d l=%0d exp a=%0d c=0 l=%0d",
                 i, la_addr[wb+i], la_code[wb+i], la_len[wb+i], 7 + i, l[i]);
      end
    end
    checks++;
    if ({eo_a, ei_a} !== 2'b01) begin
      failures++;
      $display("FAIL incomplete_flags got %b exp 01", {eo_a, ei_a});
    end
  endtask

  task automatic test_all_zero();
    int lat, wb;
    logic [2:0] snap;
    for (int i = 0; i < 5; i++) len_mem[320 + i] = 4'd0;
    wb = la_n;
    run_build(1'b0, 5, 320, 60, -1, -1, lat, snap);
    checks++;
    if (lat !== 28 || la_n - wb !== 5) begin
      failures++;
      $display("FAIL zero_latency_count got lat=%0d n=%0d exp 28 5", lat, la_n - wb);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (la_addr[wb+i] !== 9'(60 + i) || la_code[wb+i] !== 15'd0 || la_len[wb+i] !== 4'd0) begin
        failures++;
        $display("FAIL zero_entry%0d got a=%0d c=%0d l=%0d exp a=%0d c=0 l=0",
                 i, la_addr[wb+i], la_code[wb+i], la_len[wb+i], 60 + i);
      end
    end
    checks++;
    if ({eo_a, ei_a} !== 2'b00) begin
      failures++;
      $display("FAIL zero_flags got %b exp 00", {eo_a, ei_a});
    end
  endtask

  task automatic test_start_ignored();
    int ec[10] = '{2, 3, 4, 14, 5, 0, 0, 15, 0, 6};
    int lat, wb;
    logic [2:0] snap;
    wb = la_n;
    run_build(1'b0, 10, 100, 0, 3, -1, lat, snap);
    checks++;
    if (lat !== 38 || la_n - wb !== 10) begin
      failures++;
      $display("FAIL ignore_latency_count got lat=%0d n=%0d exp 38 10", lat, la_n - wb);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (la_addr[wb+i] !== 9'(i) || la_code[wb+i] !== 15'(ec[i])) begin
        failures++;
        $display("FAIL ignore_entry%0d got a=%0d c=%0d exp a=%0d c=%0d",
                 i, la_addr[wb+i], la_code[wb+i], i, ec[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int ec[10] = '{2, 3, 4, 14, 5, 0, 0, 15, 0, 6};
    int lat, wb;
    logic [2:0] snap;
    run_build(1'b0, 10, 100, 0, -1, 30, lat, snap);
    checks++;
    if (lat !== 30 || wr_en_a !== 1'b1 || busy_a !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pre got lat=%0d wr_en=%b busy=%b exp 30 1 1", lat, wr_en_a, busy_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_a, done_a, wr_en_a, eo_a, ei_a} !== 5'b0 || rd_addr_a !== 9'd0) begin
      failures++;
      $display("FAIL midreset_drop got flags=%b rd=%0d exp 00000 0",
               {busy_a, done_a, wr_en_a, eo_a, ei_a}, rd_addr_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wb = la_n;
    run_build(1'b0, 10, 100, 0, -1, -1, lat, snap);
    checks++;
    if (lat !== 38 || la_n - wb !== 10) begin
      failures++;
      $display("FAIL midreset_rebuild got lat=%0d n=%0d exp 38 10", lat, la_n - wb);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (la_addr[wb+i] !== 9'(i) || la_code[wb+i] !== 15'(ec[i])) begin
        failures++;
        $display("FAIL midreset_entry%0d got a=%0d c=%0d exp a=%0d c=%0d",
                 i, la_addr[wb+i], la_code[wb+i], i, ec[i]);
      end
    end
  endtask

  initial begin
    start_a  = 1'b0;
    start_b  = 1'b0;
    sym_num  = '0;
    buf_base = '0;
    tbl_base = '0;
    rst_n    = 1'b0;
    for (int i = 0; i < 512; i++) len_mem[i] = 4'd0;
    test_reset();
    test_basic();
    test_rfc();
    test_bit_reverse();
    test_over();
    test_incomplete();
    test_all_zero();
    test_start_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
